// File: rtl/display_bcd.sv
// display_bcd: converts a signed 16-bit result to sign + 5 BCD digits with an
// iterative double-dabble engine, then drives a 6-position time-multiplexed
// active-low seven-segment display with leading-zero blanking.
//
// Ports:
//   clk      - rising-edge clock
//   nRST     - asynchronous active-low reset
//   value_in - two's-complement value to convert
//   load     - start conversion (sampled in idle only)
//   busy     - conversion in progress
//   done     - one-cycle pulse when bcd/sign update
//   sign     - 1 = last converted value was negative
//   bcd      - magnitude, digit 4 in [19:16] .. digit 0 in [3:0]
//   seg_n    - active-low segments {g,f,e,d,c,b,a}
//   dig_n    - active-low one-hot position enable, bit 0 = units, bit 5 = sign
module display_bcd #(
  parameter int unsigned REFRESH_DIV   = 1000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [19:0] bcd,
  output logic [6:0]  seg_n,
  output logic [5:0]  dig_n
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_t;

  state_t          state_q;
  logic            neg_q;
  logic [15:0]     mag_q;
  logic [19:0]     scratch_q;
  logic [19:0]     scratch_adj;
  logic [3:0]      iter_q;
  logic [CntW-1:0] refresh_q;
  logic [2:0]      idx_q;
  logic [3:0]      digit;
  logic            lead_zero;
  logic [6:0]      seg_d;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      sign      <= 1'b0;
      bcd       <= '0;
      neg_q     <= 1'b0;
      mag_q     <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            neg_q     <= value_in[15];
            mag_q     <= value_in[15] ? (~value_in + 16'd1) : value_in;
            scratch_q <= '0;
            iter_q    <= '0;
            busy      <= 1'b1;
            state_q   <= StConv;
          end
        end
        StConv: begin
          {scratch_q, mag_q} <= {scratch_adj, mag_q} << 1;
          iter_q             <= iter_q + 4'd1;
          if (iter_q == 4'd15) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          bcd     <= scratch_q;
          sign    <= neg_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Digit select; lead_zero means this digit and all above it are zero.
  always_comb begin
    digit     = 4'd0;
    lead_zero = 1'b0;
    seg_d     = SegBlank;
    unique case (idx_q)
      3'd0: digit = bcd[3:0];
      3'd1: begin digit = bcd[7:4];   lead_zero = (bcd[19:4]  == '0); end
      3'd2: begin digit = bcd[11:8];  lead_zero = (bcd[19:8]  == '0); end
      3'd3: begin digit = bcd[15:12]; lead_zero = (bcd[19:12] == '0); end
      3'd4: begin digit = bcd[19:16]; lead_zero = (bcd[19:16] == '0); end
      default: ;
    endcase
    if (idx_q == 3'd5) begin
      seg_d = sign ? SegMinus : SegBlank;
    end else if (idx_q > 3'd5) begin
      seg_d = SegBlank;
    end else if (BLANK_LEADING && lead_zero) begin
      seg_d = SegBlank;
    end else begin
      seg_d = seg_enc(digit);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      refresh_q <= '0;
      idx_q     <= '0;
      dig_n     <= 6'b111110;
      seg_n     <= 7'b1000000;
    end else begin
      if (refresh_q == CntW'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        idx_q     <= (idx_q >= 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
      dig_n <= ~(6'd1 << idx_q);
      seg_n <= seg_d;
    end
  end

endmodule

// File: doc/display_bcd.md
# display_bcd

Output stage directly downstream of the `gencon` calculator controller. It takes the signed 16-bit result (`display_output`) when the controller signals completion and converts it to sign plus 5 BCD digits with an iterative double-dabble engine. It then drives a 6-position, time-multiplexed, active-low seven-segment display. Leading zeros are blanked, and the minus sign is shown in the leftmost position.

## Interface
- `REFRESH_DIV`, default 1000: clock cycles each display position stays active; must be ≥1.
- `BLANK_LEADING`, default 1: 1 blanks zero digits above the most significant nonzero digit; 0 shows all 5 digits.
- `clk`, input, 1: single clock; everything is rising-edge.
- `nRST`, input, 1: asynchronous, active-low reset.
- `value_in`, input, 16: two's-complement result from `gencon.display_output`.
- `load`, input, 1: start conversion; driven from `gencon.complete`; level or pulse accepted.
- `busy`, output, 1: conversion in progress.
- `done`, output, 1: one-cycle pulse when `bcd`/`sign` have been updated.
- `sign`, output, 1: 1 = result negative.
- `bcd`, output, 20: magnitude, digit 4 (ten-thousands) in [19:16] down to digit 0 (units) in [3:0].
- `seg_n`, output, 7: active-low segments {g,f,e,d,c,b,a}.
- `dig_n`, output, 6: active-low one-hot position enable; bit 0 = rightmost (units), bit 5 = sign position.

## Operation
- States: IDLE, CONV, DONE.
- **IDLE:** `busy`=0. When `load`=1 at a clock edge:
  - capture `neg = value_in[15]`;
  - capture `mag` (16-bit unsigned) = `value_in[15] ? (~value_in + 1) : value_in`;
  - clear the 20-bit scratch BCD;
  - clear the iteration counter;
  - go to CONV.
- 0x8000 gives `mag` = 32768; this is correct unsigned and needs no special case.
- **CONV:** one iteration per cycle, 16 iterations total. Each iteration:
  - add 3 to every scratch nibble ≥5;
  - shift {scratch, `mag`} left by 1.
  - After the 16th iteration, go to DONE.
- **DONE:** load `bcd` ← scratch and `sign` ← `neg`; assert `done`=1 for this cycle only; return to IDLE.
- `load` is ignored outside IDLE; in-flight operands are never overwritten.
- A `load` held high re-triggers in IDLE, so a level `complete` causes repeated identical conversions; this is harmless.
- `bcd`/`sign` change only in DONE, so the display never shows intermediate values.
- **Display scan:**
  - A refresh counter counts 0..`REFRESH_DIV`-1. On the terminal count it returns to 0 and the position index advances 0→1→…→5→0.
  - Positions 0–4 show BCD digits 0–4. Position 5 shows '-' when `sign`=1, blank otherwise.
  - Position 0 is never blanked.
  - With `BLANK_LEADING`=1, position k (1–4) is blanked when digits k..4 are all zero.
  - Encodings (`seg_n`): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, blank=1111111.
  - BCD digit values 10–15 cannot occur; if seen, they are shown as blank.
- **Reset (async, any state, including mid-CONV):**
  - state IDLE; `busy`=0, `done`=0, `sign`=0, `bcd`=0;
  - scratch, `mag` and iteration counter cleared;
  - refresh counter 0, index 0;
  - `dig_n`=111110, `seg_n`=1000000.
  - An aborted conversion produces no `done`.

## Timing
- `load` sampled high at edge T0:
  - `busy`=1 from after T0 until after edge T0+17;
  - iterations at edges T0+1..T0+16;
  - DONE is registered at edge T0+17;
  - `done`=1, `bcd`/`sign` valid from after edge T0+17.
- Latency is 17 cycles; the next `load` is accepted at edge T0+18 or later. Throughput is one conversion per 18 cycles.
- `seg_n`/`dig_n` are registered from the index and the current `bcd`/`sign`.
  - A new result appears at the active position within 1 cycle of `done`.
  - The index advances every `REFRESH_DIV` cycles; a full frame is 6×`REFRESH_DIV` cycles.
- Exactly one `dig_n` bit is low at all times after reset.
- The scan runs continuously and independently of conversions.

## Test plan
- **Reset:** assert `nRST`=0 asynchronously mid-cycle → immediately `busy`=0, `done`=0, `sign`=0, `bcd`=0x00000, `dig_n`=111110, `seg_n`=1000000.
- **Positive value:** `load`=1 for one cycle with `value_in`=3345 → `done` exactly 17 edges later, `bcd`=0x03345, `sign`=0, `busy` high for exactly 17 cycles.
- **Negative value and scan:** `value_in`=0xFFD8 (-40), `REFRESH_DIV`=2 → `bcd`=0x00040, `sign`=1. Scan must show:
  - position 0 = 1000000 and position 1 = 0011001;
  - positions 2–4 = 1111111;
  - position 5 = 0111111;
  - each position held exactly 2 cycles.
- **Extremes:**
  - 0x8000 → `bcd`=0x32768, `sign`=1;
  - 0x7FFF → `bcd`=0x32767, `sign`=0;
  - 0x0000 → `bcd`=0, `sign`=0, only position 0 lit with '0'.
- **Load while busy:** second `load` with 0x0001 at T0+5 after `load` of 0xFFF6 (-10) → single `done` with `bcd`=0x00010, `sign`=1; no second conversion until after DONE.
- **Reset mid-conversion:** `nRST` pulse at T0+8 → no `done`, outputs at reset values. A fresh `load` of 12 then completes normally with `bcd`=0x00012.
